// File: rtl/uart_tx_port_if.sv
// IO-bus view of the UART transmit port: controller strobes and data in,
// status readback and the serial line out.
interface uart_tx_port_if;
  logic        txwrite;
  logic        txread;
  logic        txcs;
  logic [1:0]  txaddr;
  logic [7:0]  txwdata;
  logic [15:0] txrdata;
  logic        tx;

  modport master (
    output txwrite,
    output txread,
    output txcs,
    output txaddr,
    output txwdata,
    input  txrdata,
    input  tx
  );

  modport slave (
    input  txwrite,
    input  txread,
    input  txcs,
    input  txaddr,
    input  txwdata,
    output txrdata,
    output tx
  );
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by IO writes, baud-rate
// FSM serialising onto tx, registered status readback.
module uart_tx_port #(
  parameter int unsigned CLK_HZ     = 23_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_port_if.slave  bus
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned BCW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  localparam logic [BCW-1:0] BAUD_MAX  = BCW'(DIV - 1);
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                r_state;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic [7:0]            r_shift;
  logic [2:0]            r_bitcnt;
  logic [BCW-1:0]        r_baud;
  logic                  r_tx;
  logic [15:0]           r_rdata;

  state_e                w_state_d;
  logic [7:0]            w_shift_d;
  logic [2:0]            w_bitcnt_d;
  logic [BCW-1:0]        w_baud_d;
  logic                  w_tx_d;
  logic                  w_busy;
  logic                  w_pop;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_read;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wrap;
  logic [3:0]            w_count4;
  logic [15:0]           w_status;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_CNT);
  assign w_push_req = bus.txcs & bus.txwrite & (bus.txaddr == 2'b00);
  // Fullness is judged before any same-cycle pop, so a full FIFO always drops.
  assign w_push     = w_push_req & ~w_full;
  assign w_read     = bus.txcs & bus.txread & (bus.txaddr == 2'b00);
  assign w_wrap     = (r_baud == BAUD_MAX);
  assign w_count4   = 4'(r_count);
  assign w_status   = {8'h00, w_count4, r_overflow, w_busy, w_full, w_empty};

  // State register and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_baud     <= '0;
      r_tx       <= 1'b1;
      r_rdata    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_bitcnt <= w_bitcnt_d;
      r_baud   <= w_baud_d;
      r_tx     <= w_tx_d;
      r_rdata  <= w_read ? w_status : 16'h0000;
      if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A dropped write in the same cycle as a status read keeps the flag set.
      if (w_push_req && w_full) r_overflow <= 1'b1;
      else if (w_read)          r_overflow <= 1'b0;
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= bus.txwdata;
  end

  // Next-state logic.
  always_comb begin
    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_bitcnt_d = r_bitcnt;
    w_baud_d   = r_baud;
    w_pop      = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_d  = r_mem[r_rptr];
          w_bitcnt_d = '0;
          w_baud_d   = '0;
          w_state_d  = StStart;
        end
      end
      StStart: begin
        w_baud_d = w_wrap ? '0 : r_baud + BCW'(1);
        if (w_wrap) w_state_d = StData;
      end
      StData: begin
        w_baud_d = w_wrap ? '0 : r_baud + BCW'(1);
        if (w_wrap) begin
          w_shift_d  = {1'b0, r_shift[7:1]};
          w_bitcnt_d = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_d = StStop;
        end
      end
      StStop: begin
        w_baud_d = w_wrap ? '0 : r_baud + BCW'(1);
        if (w_wrap) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic: line level is computed from the next state and registered.
  always_comb begin
    w_busy = (r_state != StIdle);
    case (w_state_d)
      StStart: w_tx_d = 1'b0;
      StData:  w_tx_d = w_shift_d[0];
      default: w_tx_d = 1'b1;
    endcase
  end

  assign bus.tx      = r_tx;
  assign bus.txrdata = r_rdata;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: written bytes are queued, a line monitor
// decodes 8N1 frames and compares them in order.
module tb_uart_tx_port;

  localparam int DIV = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_tx_port_if bus_if();

  uart_tx_port #(
    .CLK_HZ    (1000),
    .BAUD      (100),
    .DEPTH_LOG2(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  int         cyc     = 0;
  logic [7:0] sb [$];
  int         fall_q [$];
  int         frames_rx  = 0;
  bit         mon_active = 1'b0;
  int         mon_off    = 0;
  logic [7:0] mon_byte;
  logic       mon_prev   = 1'b1;
  logic [7:0] exp_byte;
  logic [15:0] rd;
  logic [9:0]  pat;
  int          f0;

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line monitor: samples mid-bit, frame offset 0 is the first low cycle.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      mon_active = 1'b0;
      mon_prev   = 1'b1;
    end else begin
      if (!mon_active) begin
        if (mon_prev && !bus_if.tx) begin
          mon_active = 1'b1;
          mon_off    = 0;
          fall_q.push_back(cyc);
        end
      end else begin
        mon_off++;
        if (mon_off == DIV / 2) begin
          check_eq("start_bit", bus_if.tx, 1'b0);
        end else if ((mon_off % DIV) == DIV / 2 && mon_off < 9 * DIV) begin
          mon_byte[mon_off / DIV - 1] = bus_if.tx;
        end else if (mon_off == 9 * DIV + DIV / 2) begin
          check_eq("stop_bit", bus_if.tx, 1'b1);
          check_eq("frame_expected", sb.size() > 0, 1'b1);
          if (sb.size() > 0) begin
            exp_byte = sb.pop_front();
            check_eq("frame_data", mon_byte, exp_byte);
          end
          frames_rx++;
          mon_active = 1'b0;
        end
      end
      mon_prev = bus_if.tx;
    end
  end

  task automatic bus_write(input logic [1:0] addr, input logic cs, input logic [7:0] data);
    bus_if.txaddr  = addr;
    bus_if.txcs    = cs;
    bus_if.txwrite = 1'b1;
    bus_if.txwdata = data;
    @(negedge clock);
    bus_if.txwrite = 1'b0;
    bus_if.txcs    = 1'b0;
    bus_if.txaddr  = 2'b00;
  endtask

  task automatic send(input logic [7:0] data, input bit accepted);
    bus_write(2'b00, 1'b1, data);
    if (accepted) sb.push_back(data);
  endtask

  task automatic bus_read(input logic [1:0] addr, input logic cs, output logic [15:0] data);
    bus_if.txaddr = addr;
    bus_if.txcs   = cs;
    bus_if.txread = 1'b1;
    @(negedge clock);
    data = bus_if.txrdata;
    bus_if.txread = 1'b0;
    bus_if.txcs   = 1'b0;
    bus_if.txaddr = 2'b00;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || mon_active) && k < budget) begin
      @(negedge clock);
      k++;
    end
    check_eq("drain_done", (sb.size() == 0 && !mon_active), 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.txwrite = 1'b0;
    bus_if.txread  = 1'b0;
    bus_if.txcs    = 1'b0;
    bus_if.txaddr  = 2'b00;
    bus_if.txwdata = 8'h00;

    // 1: reset and idle
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    check_eq("t1_tx_idle", bus_if.tx, 1'b1);
    check_eq("t1_rdata_idle", bus_if.txrdata, 16'h0000);
    bus_read(2'b00, 1'b1, rd);
    check_eq("t1_status", rd, 16'h0001);

    // 2: single frame, exact waveform
    send(8'hA5, 1'b1);
    check_eq("t2_no_early_fall", bus_if.tx, 1'b1);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 10 * DIV; j++) begin
      @(negedge clock);
      check_eq("t2_line", bus_if.tx, pat[j / DIV]);
    end
    bus_read(2'b00, 1'b1, rd);
    check_eq("t2_busy_last", rd, 16'h0005);
    bus_read(2'b00, 1'b1, rd);
    check_eq("t2_busy_clear", rd, 16'h0001);
    drain(50);

    // 3: three back-to-back bytes
    fall_q.delete();
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    bus_read(2'b00, 1'b1, rd);
    check_eq("t3_status", rd, 16'h0024);
    drain(500);
    check_eq("t3_frames", fall_q.size(), 3);
    if (fall_q.size() == 3) begin
      check_eq("t3_gap1", fall_q[1] - fall_q[0], 10 * DIV + 1);
      check_eq("t3_gap2", fall_q[2] - fall_q[1], 10 * DIV + 1);
    end

    // 4: overfill
    f0 = frames_rx;
    for (int i = 0; i < 10; i++) send(8'h40 + 8'(i), i < 9);
    bus_read(2'b00, 1'b1, rd);
    check_eq("t4_status_ovf", rd, 16'h008E);
    bus_read(2'b00, 1'b1, rd);
    check_eq("t4_status_cleared", rd, 16'h0086);
    drain(1300);
    repeat (150) @(negedge clock);
    check_eq("t4_frame_count", frames_rx - f0, 9);

    // 5: reset mid-frame
    f0 = frames_rx;
    send(8'hEF, 1'b1);
    send(8'h33, 1'b1);
    repeat (54) @(negedge clock);
    check_eq("t5_bit4_low", bus_if.tx, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t5_async_tx", bus_if.tx, 1'b1);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bus_read(2'b00, 1'b1, rd);
    check_eq("t5_status", rd, 16'h0001);
    repeat (300) @(negedge clock);
    check_eq("t5_no_frames", frames_rx - f0, 0);
    check_eq("t5_tx_idle", bus_if.tx, 1'b1);

    // 6: ignored offsets and chip-select
    f0 = frames_rx;
    bus_write(2'b01, 1'b1, 8'h55);
    bus_write(2'b00, 1'b0, 8'h66);
    repeat (30) @(negedge clock);
    bus_read(2'b00, 1'b1, rd);
    check_eq("t6_status", rd, 16'h0001);
    bus_read(2'b10, 1'b1, rd);
    check_eq("t6_read_off2", rd, 16'h0000);
    bus_read(2'b00, 1'b0, rd);
    check_eq("t6_read_nocs", rd, 16'h0000);
    check_eq("t6_no_frames", frames_rx - f0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
